// File: rtl/seq_alu_w.sv
// seq_alu_w: multi-cycle serial-operand ALU (add, sub, signed Booth mul, unsigned restoring div).
// Latency: B captured at edge t0 -> ready in cycles t0+N+1, t0+N+2 (N=1 add/sub, N=W mul/div).
// Backpressure: none; valid is only honoured in IDLE (A beat) and LOAD_B (B beat), ignored otherwise.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-high reset
//   in        - operand beat (A, then B)
//   op_codes  - 00 add, 01 sub, 10 mul (signed), 11 div (unsigned); sampled with A
//   valid     - qualifies in / op_codes
//   o         - result word (word0 while in OUT_LO, word1 while in OUT_HI)
//   ready     - high for the two result cycles
//   busy      - high whenever the FSM is not IDLE
//   div0      - pulse with word0 of a divide by zero
module seq_alu_w #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  input  logic [1:0]   op_codes,
  input  logic         valid,
  output logic [W-1:0] o,
  output logic         ready,
  output logic         busy,
  output logic         div0
);

  localparam int CNT_W = $clog2(W + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    EXEC   = 3'd2,
    OUT_LO = 3'd3,
    OUT_HI = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       op;
  logic [W-1:0]     b;
  // acc: Booth high half / divide remainder / add-sub word1.
  // q:   holds A on capture; Booth low half / divide quotient / add-sub word0.
  logic [W-1:0]     acc;
  logic [W-1:0]     q;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;

  logic [W-1:0]     acc_nx;
  logic [W-1:0]     q_nx;
  logic             q_m1_nx;
  logic [W:0]       sum;
  logic [W:0]       diff;
  logic [W:0]       booth;
  logic [W:0]       rem_sh;
  logic [W:0]       trial;
  logic             rem_ge;

  assign busy = (state != IDLE);

  // One iteration of the selected operation, computed from the current registers.
  always_comb begin
    sum     = {1'b0, q} + {1'b0, b};
    diff    = {1'b0, q} - {1'b0, b};

    // Booth add/sub is done one bit wider so that subtracting -2^(W-1)
    // cannot overflow; the shift then drops the extra bit back out.
    booth   = {acc[W-1], acc};
    case ({q[0], q_m1})
      2'b01:   booth = {acc[W-1], acc} + {b[W-1], b};
      2'b10:   booth = {acc[W-1], acc} - {b[W-1], b};
      default: booth = {acc[W-1], acc};
    endcase

    // Restoring divide: shift next dividend bit into the partial remainder.
    // A set top bit means the shifted remainder already exceeds any W-bit
    // divisor, so the trial subtraction's borrow is only meaningful otherwise.
    rem_sh  = {acc, q[W-1]};
    trial   = rem_sh - {1'b0, b};
    rem_ge  = rem_sh[W] | ~trial[W];

    acc_nx  = acc;
    q_nx    = q;
    q_m1_nx = q_m1;
    case (op)
      OP_ADD: begin
        q_nx   = sum[W-1:0];
        acc_nx = {{(W-1){1'b0}}, sum[W]};
      end
      OP_SUB: begin
        q_nx   = diff[W-1:0];
        acc_nx = {{(W-1){1'b0}}, diff[W]};
      end
      OP_MUL: begin
        acc_nx  = booth[W:1];
        q_nx    = {booth[0], q[W-1:1]};
        q_m1_nx = q[0];
      end
      default: begin
        if (rem_ge) begin
          acc_nx = trial[W-1:0];
          q_nx   = {q[W-2:0], 1'b1};
        end else begin
          acc_nx = rem_sh[W-1:0];
          q_nx   = {q[W-2:0], 1'b0};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= 2'b00;
      b     <= '0;
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      o     <= '0;
      ready <= 1'b0;
      div0  <= 1'b0;
    end else begin
      ready <= 1'b0;
      div0  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            q     <= in;
            op    <= op_codes;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (valid) begin
            b     <= in;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= op[1] ? CNT_W'(W) : CNT_W'(1);
            state <= EXEC;
          end
        end
        EXEC: begin
          acc  <= acc_nx;
          q    <= q_nx;
          q_m1 <= q_m1_nx;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Final iteration: word0 goes straight to the output register,
            // word1 is left in acc for the next cycle.
            state <= OUT_LO;
            ready <= 1'b1;
            o     <= q_nx;
            div0  <= (op == 2'b11) && (b == '0);
          end
        end
        OUT_LO: begin
          state <= OUT_HI;
          ready <= 1'b1;
          o     <= acc;
        end
        OUT_HI: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_w.sv
// tb_seq_alu_w: scoreboard bench for seq_alu_w at W=8.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_seq_alu_w;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in;
  logic [1:0]   op_codes;
  logic         valid;
  logic [W-1:0] o;
  logic         ready;
  logic         busy;
  logic         div0;

  always #5 clk = ~clk;

  seq_alu_w #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .op_codes (op_codes),
    .valid    (valid),
    .o        (o),
    .ready    (ready),
    .busy     (busy),
    .div0     (div0)
  );

  typedef struct {
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    logic         d0;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  int   beat     = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] bb);
    exp_t                    e;
    logic [W:0]              s;
    logic signed [2*W-1:0]   p;
    e.d0 = 1'b0;
    e.w0 = '0;
    e.w1 = '0;
    case (opc)
      2'b00: begin
        s    = {1'b0, a} + {1'b0, bb};
        e.w0 = s[W-1:0];
        e.w1 = {{(W-1){1'b0}}, s[W]};
      end
      2'b01: begin
        e.w0 = a - bb;
        e.w1 = (a < bb) ? W'(1) : W'(0);
      end
      2'b10: begin
        p    = $signed(a) * $signed(bb);
        e.w0 = p[W-1:0];
        e.w1 = p[2*W-1:W];
      end
      default: begin
        if (bb == '0) begin
          e.w0 = '1;
          e.w1 = a;
          e.d0 = 1'b1;
        end else begin
          e.w0 = a / bb;
          e.w1 = a % bb;
        end
      end
    endcase
    return e;
  endfunction

  // Result monitor: pops one expectation per ready pulse.
  always @(negedge clk) begin
    if (rst) begin
      beat = 0;
    end else if (ready) begin
      if (beat == 0) begin
        if (sb.size() == 0) begin
          check("ready_unexpected", ready, 0);
        end else begin
          cur = sb.pop_front();
          check("word0", o, cur.w0);
          check("div0_lo", div0, cur.d0);
          beat = 1;
        end
      end else begin
        check("word1", o, cur.w1);
        check("div0_hi", div0, 0);
        beat = 0;
      end
    end else if (beat == 1) begin
      check("ready_second_cycle", ready, 1);
      beat = 0;
    end
  end

  // Drive A then B; returns at the negedge of the second result cycle so the
  // next call presents A in the first IDLE cycle.
  task automatic do_op(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] bb,
                       input bit hold);
    int lat;
    int n;
    sb.push_back(model(opc, a, bb));
    n = opc[1] ? W : 1;
    @(negedge clk);
    valid    = 1'b1;
    in       = a;
    op_codes = opc;
    @(negedge clk);
    check("busy_load_b", busy, 1);
    in       = bb;
    op_codes = 2'($urandom);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (hold) in = W'($urandom);
      else      valid = 1'b0;
      if (ready) break;
    end
    valid = 1'b0;
    check("latency", lat, n + 1);
    @(negedge clk);
  endtask

  initial begin
    int rdy_seen;
    rst      = 1'b1;
    valid    = 1'b0;
    in       = '0;
    op_codes = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_o", o, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_div0", div0, 0);
    rst = 1'b0;

    do_op(2'b00, 8'd200, 8'd100, 1'b0);
    do_op(2'b01, 8'd3,   8'd5,   1'b0);
    do_op(2'b10, 8'd3,   8'd2,   1'b0);
    do_op(2'b10, 8'hFD,  8'd5,   1'b0);
    do_op(2'b11, 8'd100, 8'd7,   1'b0);
    do_op(2'b11, 8'd100, 8'd0,   1'b0);
    do_op(2'b10, 8'h80,  8'h80,  1'b1);
    do_op(2'b01, 8'd9,   8'd9,   1'b1);
    do_op(2'b10, 8'h7F,  8'h80,  1'b0);
    do_op(2'b11, 8'd5,   8'd200, 1'b0);

    for (int i = 0; i < 12; i++) begin
      do_op(2'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    end

    // Abort a multiply three cycles into EXEC.
    @(negedge clk);
    valid    = 1'b1;
    in       = 8'd7;
    op_codes = 2'b10;
    @(negedge clk);
    in = 8'd9;
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_o", o, 0);
    check("abort_ready", ready, 0);
    check("abort_busy", busy, 0);
    check("abort_div0", div0, 0);
    @(negedge clk);
    rst = 1'b0;
    rdy_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (ready) rdy_seen++;
    end
    check("abort_no_ready", rdy_seen, 0);

    do_op(2'b00, 8'd1, 8'd1, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
